// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and defaults for the hazard scoreboard.
//   DEF_NREGS / DEF_MAXLAT / DEF_PC_REG : default parameter values
//   regIdx_t : register index at the default register count
//   lat_t    : latency/countdown value at the default maximum latency
package hazard_pkg;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_MAXLAT = 4;
  localparam int DEF_PC_REG = 15;

  typedef logic [$clog2(DEF_NREGS)-1:0]    regIdx_t;
  typedef logic [$clog2(DEF_MAXLAT+1)-1:0] lat_t;
endpackage

// File: rtl/sb_entry.sv
// sb_entry -- one scoreboard countdown for a single architectural register.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load loadVal this cycle (overrides the decrement)
//   loadVal    : cycles until the pending result is forwardable
//   cnt        : current countdown value
//   busy       : countdown nonzero, i.e. a write is pending
module sb_entry #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  output logic [CW-1:0] cnt,
  output logic          busy
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= loadVal;
    else if (cnt != '0)    cnt <= cnt - CW'(1);
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- per-register countdown scoreboard that stalls decode on
// RAW, WAW and control (PC write pending) hazards.
//   clk, reset          : clock, asynchronous active-high reset
//   issue_*             : decode-stage instruction (sources, destination, latency)
//   flush               : kill the decode-stage instruction this cycle
//   stall               : combinational hold of fetch/decode
//   fwd1, fwd2          : take the source from the execute result
//   busy                : per-register pending-write flags
//   stall_count         : saturating count of stall cycles
// Build option: HAZARD_FORWARD_EN -- when defined, a source whose producer is
// one cycle from done is forwarded instead of stalled; otherwise fwd1/fwd2 are 0.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int MAXLAT = DEF_MAXLAT,
  parameter int PC_REG = DEF_PC_REG,
  localparam int CW    = $clog2(MAXLAT+1),
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_ra1,
  input  logic [RW-1:0]    issue_ra2,
  input  logic             issue_use1,
  input  logic             issue_use2,
  input  logic             issue_wr,
  input  logic [RW-1:0]    issue_wa,
  input  logic [CW-1:0]    issue_lat,
  input  logic             flush,
  output logic             stall,
  output logic             fwd1,
  output logic             fwd2,
  output logic [NREGS-1:0] busy,
  output logic [15:0]      stall_count
);
`ifdef HAZARD_FORWARD_EN
  localparam logic [CW-1:0] THR = CW'(1);
`else
  localparam logic [CW-1:0] THR = '0;
`endif

  logic [NREGS-1:0][CW-1:0] cntAll;
  logic [CW-1:0]            loadVal;
  logic                     raw1, raw2, waw, ctrl, accept;

  // Latencies beyond MAXLAT are clamped; the counter never needs more.
  assign loadVal = (issue_lat > CW'(MAXLAT)) ? CW'(MAXLAT) : issue_lat;

  // All hazards look at pre-load counter values, so an instruction that reads
  // and writes the same register checks against the older producer.
  assign raw1   = issue_use1 && (cntAll[issue_ra1] > THR);
  assign raw2   = issue_use2 && (cntAll[issue_ra2] > THR);
  assign waw    = issue_wr   && (cntAll[issue_wa]  > issue_lat);
  assign ctrl   = (cntAll[PC_REG] != '0);
  assign stall  = issue_valid && !flush && (raw1 || raw2 || waw || ctrl);
  assign accept = issue_valid && !stall && !flush;

`ifdef HAZARD_FORWARD_EN
  assign fwd1 = issue_valid && !flush && issue_use1 && (cntAll[issue_ra1] == CW'(1));
  assign fwd2 = issue_valid && !flush && issue_use2 && (cntAll[issue_ra2] == CW'(1));
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  for (genvar r = 0; r < NREGS; r++) begin : gEntry
    sb_entry #(.CW(CW)) uEntry (
      .clk     (clk),
      .reset   (reset),
      .load    (accept && issue_wr && (issue_lat != '0) && (issue_wa == RW'(r))),
      .loadVal (loadVal),
      .cnt     (cntAll[r]),
      .busy    (busy[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the pending-write countdowns.
module tb_hazard_scoreboard;
  localparam int NREGS  = 16;
  localparam int MAXLAT = 12;
  localparam int PC_REG = 15;
  localparam int CW     = 4;
  localparam int RW     = 4;
`ifdef HAZARD_FORWARD_EN
  localparam int T   = 1;
  localparam bit FWD = 1'b1;
`else
  localparam int T   = 0;
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic issue_valid, issue_use1, issue_use2, issue_wr, flush;
  logic [RW-1:0] issue_ra1, issue_ra2, issue_wa;
  logic [CW-1:0] issue_lat;
  logic stall, fwd1, fwd2;
  logic [NREGS-1:0] busy;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREGS(NREGS), .MAXLAT(MAXLAT), .PC_REG(PC_REG)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_ra1(issue_ra1), .issue_ra2(issue_ra2),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .issue_wr(issue_wr), .issue_wa(issue_wa), .issue_lat(issue_lat),
    .flush(flush), .stall(stall), .fwd1(fwd1), .fwd2(fwd2),
    .busy(busy), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycles remaining until each register's pending result is ready.
  int mc[NREGS];
  int msc;
  bit eStall;
  bit mv, mu1, mu2, mwr, mfl;
  int mra1, mra2, mwa, mlat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int r = 0; r < NREGS; r++) mc[r] = 0;
    msc = 0;
  endtask

  task automatic setIn(input bit v, input int ra1, input bit u1, input int ra2, input bit u2,
                       input bit wr, input int wa, input int lat, input bit fl);
    mv = v; mra1 = ra1; mu1 = u1; mra2 = ra2; mu2 = u2; mwr = wr; mwa = wa; mlat = lat; mfl = fl;
    issue_valid = v; issue_ra1 = RW'(ra1); issue_use1 = u1; issue_ra2 = RW'(ra2);
    issue_use2 = u2; issue_wr = wr; issue_wa = RW'(wa); issue_lat = CW'(lat); flush = fl;
  endtask

  task automatic drive(input bit v, input int ra1, input bit u1, input int ra2, input bit u2,
                       input bit wr, input int wa, input int lat, input bit fl);
    @(negedge clk);
    setIn(v, ra1, u1, ra2, u2, wr, wa, lat, fl);
    #1;
  endtask

  task automatic checkOuts();
    bit r1, r2, w, c, ef1, ef2;
    logic [NREGS-1:0] eb;
    r1 = mu1 && (mc[mra1] > T);
    r2 = mu2 && (mc[mra2] > T);
    w  = mwr && (mc[mwa] > mlat);
    c  = (mc[PC_REG] != 0);
    eStall = mv && !mfl && (r1 || r2 || w || c);
    ef1 = FWD && mv && !mfl && mu1 && (mc[mra1] == 1);
    ef2 = FWD && mv && !mfl && mu2 && (mc[mra2] == 1);
    for (int r = 0; r < NREGS; r++) eb[r] = (mc[r] != 0);
    chk("stall", 32'(stall), 32'(eStall));
    chk("fwd1", 32'(fwd1), 32'(ef1));
    chk("fwd2", 32'(fwd2), 32'(ef2));
    chk("busy", 32'(busy), 32'(eb));
    chk("stallCount", 32'(stall_count), 32'(msc));
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    if (eStall && msc < 65535) msc++;
    acc = mv && !eStall && !mfl;
    for (int r = 0; r < NREGS; r++) begin
      if (acc && mwr && mlat != 0 && mwa == r) mc[r] = (mlat > MAXLAT) ? MAXLAT : mlat;
      else if (mc[r] > 0) mc[r]--;
    end
  endtask

  task automatic step(input bit v, input int ra1, input bit u1, input int ra2, input bit u2,
                      input bit wr, input int wa, input int lat, input bit fl);
    drive(v, ra1, u1, ra2, u2, wr, wa, lat, fl);
    checkOuts();
    tick();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse between clock edges; outputs must clear without a clock.
  task automatic doReset();
    @(negedge clk);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    clearModel();
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstCount", 32'(stall_count), 32'd0);
    chk("rstStall", 32'(stall), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearModel();
    reset = 1'b1;
    #1;
    chk("initBusy", 32'(busy), 32'd0);
    chk("initCount", 32'(stall_count), 32'd0);
    chk("initStall", 32'(stall), 32'd0);
    chk("initFwd", 32'({fwd1, fwd2}), 32'd0);
    #20;
    reset = 1'b0;

    // Producer R3 lat 2, consumer right behind it.
    step(1, 0, 0, 0, 0, 1, 3, 2, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("rawC1Stall", 32'(stall), 32'd1);
    checkOuts(); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("rawC2Stall", 32'(stall), 32'(!FWD));
    chk("rawC2Fwd", 32'(fwd1), 32'(FWD));
    checkOuts(); tick();
    if (!FWD) begin
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
      chk("rawC3Stall", 32'(stall), 32'd0);
      checkOuts(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rawCount", 32'(stall_count), FWD ? 32'd1 : 32'd2);
    checkOuts(); tick();

    // PC write lat 3: unrelated instructions stall three cycles.
    doReset();
    step(1, 0, 0, 0, 0, 1, 15, 3, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 2, 1, 0, 0, 0, 0);
      chk("ctrlStall", 32'(stall), 32'(i < 3));
      chk("ctrlBusy15", 32'(busy[15]), 32'(i < 3));
      checkOuts(); tick();
    end

    // WAW: R5 at 3, new write lat 1 waits until the old one is down to 1.
    doReset();
    step(1, 0, 0, 0, 0, 1, 5, 3, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
      chk("wawStall", 32'(stall), 32'(i < 2));
      checkOuts(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wawBusyNew", 32'(busy[5]), 32'd1);
    checkOuts(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wawBusyDone", 32'(busy[5]), 32'd0);
    checkOuts(); tick();

    // Flush on a RAW cycle: no stall, and its write to R9 is dropped.
    doReset();
    step(1, 0, 0, 0, 0, 1, 2, 3, 0);
    drive(1, 2, 1, 0, 0, 1, 9, 4, 1);
    chk("flushStall", 32'(stall), 32'd0);
    chk("flushFwd", 32'(fwd1), 32'd0);
    checkOuts(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flushBusy", 32'(busy), 32'h0004);
    checkOuts(); tick();

    // Reset mid-countdown discards R7; reading it afterwards is free.
    doReset();
    step(1, 0, 0, 0, 0, 1, 7, 4, 0);
    idle();
    doReset();
    drive(1, 7, 1, 7, 1, 0, 0, 0, 0);
    chk("postRstStall", 32'(stall), 32'd0);
    checkOuts(); tick();

    // Latency above MAXLAT clamps.
    step(1, 0, 0, 0, 0, 1, 4, 15, 0);
    for (int i = 0; i < MAXLAT; i++) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clampBusy", 32'(busy[4]), 32'd0);
    checkOuts(); tick();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) doReset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 1),
           ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 7),
           $urandom_range(0, 15), $urandom_range(0, 7) == 0);
    end

    // Saturation: an instruction reading and rewriting R5 keeps re-stalling.
    doReset();
    for (int i = 0; i < 80000 && msc < 65535; i++) step(1, 5, 1, 0, 0, 1, 5, MAXLAT, 0);
    for (int i = 0; i < 30; i++) step(1, 5, 1, 0, 0, 1, 5, MAXLAT, 0);
    drive(1, 5, 1, 0, 0, 1, 5, MAXLAT, 0);
    chk("satCount", 32'(stall_count), 32'h0000FFFF);
    checkOuts(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
